cu_alu_io_manager: RTL and testbench

// - Execute-stage core of the single-cycle MIPS CPU: control unit (cu), ALU (alu) and I/O manager (IOManager).
// - Decodes opcode/func, computes f/z, and serves lw/sw through an 8-word RAM or switch/LED I/O.
// - Sits between instruction decode/regfile and the regfile write-back/PC-select muxes in top.

---
 rtl/cu_alu_io_manager.sv | 175 +++++++++++++++++
 tb/tb_cu_alu_io_manager.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cu_alu_io_manager.sv
// Execute-stage core of the single-cycle MIPS CPU: control decode, ALU, and lw/sw I/O manager (8-word RAM, switches, LEDs).
// Optional build macro CU_ALU_SLT_EN adds slt/slti and ALU op 1001 (signed set-less-than).
module cu_alu_io_manager (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [31:0] ext_imm,
    input  logic [3:0]  n,
    output logic [1:0]  pcsource,
    output logic [3:0]  aluOP,
    output logic        regWE,
    output logic        imm,
    output logic        shift,
    output logic        isrt,
    output logic        sign_ext,
    output logic        jal,
    output logic        ce,
    output logic        we,
    output logic [31:0] f,
    output logic        z,
    output logic [31:0] dout,
    output logic [31:0] displaydata
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;
    localparam logic [3:0] ALU_SLT = 4'b1001;

    logic [1:0]  pcs_base;
    logic        is_beq;
    logic        is_bne;
    logic [31:0] alu_b;
    logic [5:0]  addr;
    logic [31:0] ram [0:7];

    // Branch direction is resolved after the ALU so z never feeds back into decode.
    always_comb begin
        pcs_base = 2'b00;
        aluOP    = ALU_ADD;
        regWE    = 1'b0;
        imm      = 1'b0;
        shift    = 1'b0;
        isrt     = 1'b0;
        sign_ext = 1'b0;
        jal      = 1'b0;
        ce       = 1'b0;
        we       = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                regWE = 1'b1;
                case (func)
                    FN_ADD: aluOP = ALU_ADD;
                    FN_SUB: aluOP = ALU_SUB;
                    FN_AND: aluOP = ALU_AND;
                    FN_OR:  aluOP = ALU_OR;
                    FN_XOR: aluOP = ALU_XOR;
                    FN_SLL: begin aluOP = ALU_SLL; shift = 1'b1; end
                    FN_SRL: begin aluOP = ALU_SRL; shift = 1'b1; end
                    FN_SRA: begin aluOP = ALU_SRA; shift = 1'b1; end
                    FN_JR:  begin regWE = 1'b0; pcs_base = 2'b10; end
`ifdef CU_ALU_SLT_EN
                    FN_SLT: aluOP = ALU_SLT;
`endif
                    default: regWE = 1'b0;
                endcase
            end
            OP_ADDI: begin aluOP = ALU_ADD; imm = 1'b1; isrt = 1'b1; regWE = 1'b1; sign_ext = 1'b1; end
            OP_ANDI: begin aluOP = ALU_AND; imm = 1'b1; isrt = 1'b1; regWE = 1'b1; end
            OP_ORI:  begin aluOP = ALU_OR;  imm = 1'b1; isrt = 1'b1; regWE = 1'b1; end
            OP_XORI: begin aluOP = ALU_XOR; imm = 1'b1; isrt = 1'b1; regWE = 1'b1; end
            OP_LUI:  begin aluOP = ALU_LUI; imm = 1'b1; isrt = 1'b1; regWE = 1'b1; end
`ifdef CU_ALU_SLT_EN
            OP_SLTI: begin aluOP = ALU_SLT; imm = 1'b1; isrt = 1'b1; regWE = 1'b1; sign_ext = 1'b1; end
`endif
            OP_LW: begin
                aluOP = ALU_ADD; imm = 1'b1; isrt = 1'b1; regWE = 1'b1; sign_ext = 1'b1; ce = 1'b1;
            end
            OP_SW:  begin aluOP = ALU_ADD; imm = 1'b1; sign_ext = 1'b1; we = 1'b1; end
            OP_BEQ: begin aluOP = ALU_SUB; sign_ext = 1'b1; is_beq = 1'b1; end
            OP_BNE: begin aluOP = ALU_SUB; sign_ext = 1'b1; is_bne = 1'b1; end
            OP_J:   pcs_base = 2'b11;
            OP_JAL: begin pcs_base = 2'b11; jal = 1'b1; regWE = 1'b1; end
            default: ;
        endcase
    end

    assign alu_b = imm ? ext_imm : rdata2;

    always_comb begin
        f = 32'd0;
        case (aluOP)
            ALU_ADD: f = rdata1 + alu_b;
            ALU_SUB: f = rdata1 - alu_b;
            ALU_AND: f = rdata1 & alu_b;
            ALU_OR:  f = rdata1 | alu_b;
            ALU_XOR: f = rdata1 ^ alu_b;
            ALU_SLL: f = alu_b << rdata1[4:0];
            ALU_SRL: f = alu_b >> rdata1[4:0];
            ALU_SRA: f = $signed(alu_b) >>> rdata1[4:0];
            ALU_LUI: f = {alu_b[15:0], 16'd0};
`ifdef CU_ALU_SLT_EN
            ALU_SLT: f = ($signed(rdata1) < $signed(alu_b)) ? 32'd1 : 32'd0;
`endif
            default: f = 32'd0;
        endcase
    end

    assign z = (f == 32'd0);

    always_comb begin
        pcsource = pcs_base;
        if ((is_beq && z) || (is_bne && !z))
            pcsource = 2'b01;
    end

    // addr[5] selects I/O space (switches on read, LED register on write).
    assign addr = f[5:0];

    always_comb begin
        dout = 32'd0;
        if (ce)
            dout = addr[5] ? {28'd0, n} : ram[addr[4:2]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                ram[i] <= 32'd0;
            displaydata <= 32'd0;
        end else if (we) begin
            if (addr[5])
                displaydata <= rdata2;
            else
                ram[addr[4:2]] <= rdata2;
        end
    end

endmodule

// File: tb/tb_cu_alu_io_manager.sv
// Scoreboard bench for cu_alu_io_manager: expected f/z/control/dout pushed on drive, popped and compared at negedge.
module tb_cu_alu_io_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, func;
    logic [31:0] rdata1, rdata2, ext_imm;
    logic [3:0]  n;
    logic [1:0]  pcsource;
    logic [3:0]  aluOP;
    logic        regWE, imm, shift, isrt, sign_ext, jal, ce, we;
    logic [31:0] f, dout, displaydata;
    logic        z;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [31:0] f;
        logic        z;
        logic [13:0] ctl;
        logic [31:0] dout;
    } exp_t;
    exp_t sb[$];

    cu_alu_io_manager dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func),
        .rdata1(rdata1), .rdata2(rdata2), .ext_imm(ext_imm), .n(n),
        .pcsource(pcsource), .aluOP(aluOP), .regWE(regWE), .imm(imm),
        .shift(shift), .isrt(isrt), .sign_ext(sign_ext), .jal(jal),
        .ce(ce), .we(we), .f(f), .z(z), .dout(dout), .displaydata(displaydata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // {pcsource, aluOP, regWE, imm, shift, isrt, sign_ext, jal, ce, we}
    function automatic logic [13:0] c(input logic [1:0] p, input logic [3:0] op, input logic [7:0] s);
        return {p, op, s};
    endfunction

    task automatic check_out();
        exp_t x;
        chk("sb_depth", sb.size(), 32'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({x.tag, ".f"}, f, x.f);
            chk({x.tag, ".z"}, {31'd0, z}, {31'd0, x.z});
            chk({x.tag, ".ctl"},
                {18'd0, pcsource, aluOP, regWE, imm, shift, isrt, sign_ext, jal, ce, we},
                {18'd0, x.ctl});
            chk({x.tag, ".dout"}, dout, x.dout);
        end
    endtask

    task automatic apply(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                         input logic [3:0] nn, input logic [31:0] ef, input logic [13:0] ectl,
                         input logic [31:0] edout);
        exp_t x;
        opcode = op; func = fn; rdata1 = a; rdata2 = b; ext_imm = e; n = nn;
        x.tag = tag; x.f = ef; x.z = (ef == 32'd0); x.ctl = ectl; x.dout = edout;
        sb.push_back(x);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    localparam logic [7:0] S_R    = 8'b1000_0000;
    localparam logic [7:0] S_SH   = 8'b1010_0000;
    localparam logic [7:0] S_IS   = 8'b1101_1000;
    localparam logic [7:0] S_IZ   = 8'b1101_0000;
    localparam logic [7:0] S_LW   = 8'b1101_1010;
    localparam logic [7:0] S_SW   = 8'b0100_1001;
    localparam logic [7:0] S_BR   = 8'b0000_1000;
    localparam logic [7:0] S_JAL  = 8'b1000_0100;
    localparam logic [7:0] S_NONE = 8'b0000_0000;

    initial begin
        rst = 1'b1;
        opcode = 6'd0; func = 6'd0; rdata1 = 32'd0; rdata2 = 32'd0; ext_imm = 32'd0; n = 4'd0;
        #2;
        chk("reset.displaydata", displaydata, 32'd0);
        #5;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Arithmetic / logic R-type
        apply("add", 6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0, 4'd0, 32'd12, c(2'b00, 4'b0000, S_R), 32'd0);
        apply("sub", 6'b000000, 6'b100010, 32'd3, 32'd5, 32'd0, 4'd0, 32'hFFFF_FFFE, c(2'b00, 4'b0001, S_R), 32'd0);
        apply("and", 6'b000000, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 4'd0, 32'h0000_F000, c(2'b00, 4'b0010, S_R), 32'd0);
        apply("or",  6'b000000, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 4'd0, 32'h0000_FFF0, c(2'b00, 4'b0011, S_R), 32'd0);
        apply("xor", 6'b000000, 6'b100110, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 4'd0, 32'h0000_0FF0, c(2'b00, 4'b0100, S_R), 32'd0);
        apply("addwrap", 6'b000000, 6'b100000, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd0, 32'd0, c(2'b00, 4'b0000, S_R), 32'd0);
        apply("sll", 6'b000000, 6'b000000, 32'd4, 32'd1, 32'd0, 4'd0, 32'h0000_0010, c(2'b00, 4'b0101, S_SH), 32'd0);
        apply("srl", 6'b000000, 6'b000010, 32'd4, 32'h8000_0000, 32'd0, 4'd0, 32'h0800_0000, c(2'b00, 4'b0110, S_SH), 32'd0);
        apply("sra", 6'b000000, 6'b000011, 32'd4, 32'h8000_0000, 32'd0, 4'd0, 32'hF800_0000, c(2'b00, 4'b0111, S_SH), 32'd0);
        apply("jr",  6'b000000, 6'b001000, 32'h40, 32'd0, 32'd0, 4'd0, 32'h40, c(2'b10, 4'b0000, S_NONE), 32'd0);
        apply("badfn", 6'b000000, 6'b111111, 32'd2, 32'd3, 32'd0, 4'd0, 32'd5, c(2'b00, 4'b0000, S_NONE), 32'd0);

        // I-type
        apply("addi", 6'b001000, 6'd0, 32'd10, 32'd99, 32'hFFFF_FFFF, 4'd0, 32'd9, c(2'b00, 4'b0000, S_IS), 32'd0);
        apply("andi", 6'b001100, 6'd0, 32'h0F0F, 32'd99, 32'h00FF, 4'd0, 32'h000F, c(2'b00, 4'b0010, S_IZ), 32'd0);
        apply("ori",  6'b001101, 6'd0, 32'h0F0F, 32'd99, 32'h00FF, 4'd0, 32'h0FFF, c(2'b00, 4'b0011, S_IZ), 32'd0);
        apply("xori", 6'b001110, 6'd0, 32'h0F0F, 32'd99, 32'h00FF, 4'd0, 32'h0FF0, c(2'b00, 4'b0100, S_IZ), 32'd0);
        apply("lui",  6'b001111, 6'd0, 32'd7, 32'd99, 32'h1234, 4'd0, 32'h1234_0000, c(2'b00, 4'b1000, S_IZ), 32'd0);

        // Branches and jumps
        apply("beq_t", 6'b000100, 6'd0, 32'd9, 32'd9, 32'd3, 4'd0, 32'd0, c(2'b01, 4'b0001, S_BR), 32'd0);
        apply("beq_n", 6'b000100, 6'd0, 32'd9, 32'd8, 32'd3, 4'd0, 32'd1, c(2'b00, 4'b0001, S_BR), 32'd0);
        apply("bne_t", 6'b000101, 6'd0, 32'd9, 32'd8, 32'd3, 4'd0, 32'd1, c(2'b01, 4'b0001, S_BR), 32'd0);
        apply("bne_n", 6'b000101, 6'd0, 32'd9, 32'd9, 32'd3, 4'd0, 32'd0, c(2'b00, 4'b0001, S_BR), 32'd0);
        apply("j",   6'b000010, 6'd0, 32'd1, 32'd2, 32'd0, 4'd0, 32'd3, c(2'b11, 4'b0000, S_NONE), 32'd0);
        apply("jal", 6'b000011, 6'd0, 32'd1, 32'd2, 32'd0, 4'd0, 32'd3, c(2'b11, 4'b0000, S_JAL), 32'd0);
        apply("badop", 6'b111111, 6'd0, 32'd1, 32'd2, 32'd0, 4'd0, 32'd3, c(2'b00, 4'b0000, S_NONE), 32'd0);

        // Optional set-less-than
`ifdef CU_ALU_SLT_EN
        apply("slt",  6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd0, 32'd1, c(2'b00, 4'b1001, S_R), 32'd0);
        apply("slt0", 6'b000000, 6'b101010, 32'd5, 32'd1, 32'd0, 4'd0, 32'd0, c(2'b00, 4'b1001, S_R), 32'd0);
        apply("slti", 6'b001010, 6'd0, 32'hFFFF_FFFF, 32'd1, 32'd5, 4'd0, 32'd1, c(2'b00, 4'b1001, S_IS), 32'd0);
`else
        apply("slt",  6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd0, 32'd0, c(2'b00, 4'b0000, S_NONE), 32'd0);
        apply("slti", 6'b001010, 6'd0, 32'hFFFF_FFFF, 32'd1, 32'd5, 4'd0, 32'd0, c(2'b00, 4'b0000, S_NONE), 32'd0);
`endif

        // RAM and I/O
        apply("sw4",  6'b101011, 6'd0, 32'h04, 32'h55, 32'd0, 4'd0, 32'h04, c(2'b00, 4'b0000, S_SW), 32'd0);
        apply("sw1c", 6'b101011, 6'd0, 32'h10, 32'hDEAD_BEEF, 32'h0C, 4'd0, 32'h1C, c(2'b00, 4'b0000, S_SW), 32'd0);
        apply("lw4",  6'b100011, 6'd0, 32'h04, 32'd0, 32'd0, 4'd0, 32'h04, c(2'b00, 4'b0000, S_LW), 32'h55);
        apply("lw1c", 6'b100011, 6'd0, 32'h1C, 32'd0, 32'd0, 4'd0, 32'h1C, c(2'b00, 4'b0000, S_LW), 32'hDEAD_BEEF);
        apply("lw0",  6'b100011, 6'd0, 32'd0, 32'd0, 32'd0, 4'd0, 32'd0, c(2'b00, 4'b0000, S_LW), 32'd0);
        apply("lwsw", 6'b100011, 6'd0, 32'h20, 32'd0, 32'h04, 4'hA, 32'h24, c(2'b00, 4'b0000, S_LW), 32'h0000_000A);
        chk("led.before", displaydata, 32'd0);
        apply("swled", 6'b101011, 6'd0, 32'h20, 32'd55, 32'd0, 4'd0, 32'h20, c(2'b00, 4'b0000, S_SW), 32'd0);
        chk("led.after", displaydata, 32'd55);
        apply("lw4b", 6'b100011, 6'd0, 32'h04, 32'd0, 32'd0, 4'd0, 32'h04, c(2'b00, 4'b0000, S_LW), 32'h55);

        // Asynchronous reset mid-cycle, then a store attempted while held in reset
        #2;
        rst = 1'b1;
        #1;
        chk("rst.displaydata", displaydata, 32'd0);
        apply("rst_lw4", 6'b100011, 6'd0, 32'h04, 32'd0, 32'd0, 4'd0, 32'h04, c(2'b00, 4'b0000, S_LW), 32'd0);
        apply("rst_sw",  6'b101011, 6'd0, 32'h20, 32'h77, 32'd0, 4'd0, 32'h20, c(2'b00, 4'b0000, S_SW), 32'd0);
        chk("rst.led_hold", displaydata, 32'd0);
        rst = 1'b0;
        apply("post_lw1c", 6'b100011, 6'd0, 32'h1C, 32'd0, 32'd0, 4'd0, 32'h1C, c(2'b00, 4'b0000, S_LW), 32'd0);
        chk("post.displaydata", displaydata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
